// File: rtl/stoplight_monitor.sv
// Lamp-side checker for the stoplight controller: tracks the G->Y->R phase
// sequence, latches the first fault, and reports phase lengths and rotations.
module stoplight_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_YELLOW = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] last_len,
  output logic [7:0]       rotations
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_RED,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_ORDER   = 2'd2,
    FC_SHORT_Y = 2'd3
  } fault_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);

  state_t           state;
  phase_t           phase_q;
  fault_t           code_q;
  logic [CNT_W-1:0] cnt;
  phase_t           lamp_ph;
  phase_t           next_ph;
  state_t           next_state;

  assign phase      = phase_q;
  assign fault_code = code_q;

  // Decode the sampled lamp code; PH_IDLE here marks an illegal (not one-hot) code.
  always_comb begin
    lamp_ph = PH_IDLE;
    unique case ({red, yellow, green})
      3'b001:  lamp_ph = PH_GREEN;
      3'b010:  lamp_ph = PH_YELLOW;
      3'b100:  lamp_ph = PH_RED;
      default: lamp_ph = PH_IDLE;
    endcase
  end

  always_comb begin
    next_ph    = PH_GREEN;
    next_state = S_GREEN;
    unique case (phase_q)
      PH_GREEN:  begin next_ph = PH_YELLOW; next_state = S_YELLOW; end
      PH_YELLOW: begin next_ph = PH_RED;    next_state = S_RED;    end
      default:   begin next_ph = PH_GREEN;  next_state = S_GREEN;  end
    endcase
  end

  function automatic state_t state_of(input phase_t p);
    unique case (p)
      PH_GREEN:  return S_GREEN;
      PH_YELLOW: return S_YELLOW;
      PH_RED:    return S_RED;
      default:   return S_IDLE;
    endcase
  endfunction

  // NOTE: all state uses non-blocking assignments so every branch below reads
  // the pre-edge values of cnt/phase_q, matching the one-cycle output latency.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      phase_q   <= PH_IDLE;
      fault     <= 1'b0;
      code_q    <= FC_NONE;
      cnt       <= '0;
      last_len  <= '0;
      rotations <= 8'd0;
    end else if (clr) begin
      // Clear discards the lamp sample on this edge and keeps the rotation count.
      state    <= S_IDLE;
      phase_q  <= PH_IDLE;
      fault    <= 1'b0;
      code_q   <= FC_NONE;
      cnt      <= '0;
      last_len <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (lamp_ph != PH_IDLE) begin
            state   <= state_of(lamp_ph);
            phase_q <= lamp_ph;
            cnt     <= CNT_W'(1);
          end
        end
        S_GREEN, S_YELLOW, S_RED: begin
          if (lamp_ph == PH_IDLE) begin
            state  <= S_FAULT;
            fault  <= 1'b1;
            code_q <= FC_ILLEGAL;
          end else if (lamp_ph == phase_q) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end else if (lamp_ph != next_ph) begin
            state  <= S_FAULT;
            fault  <= 1'b1;
            code_q <= FC_ORDER;
          end else if (state == S_YELLOW && cnt < MIN_Y) begin
            // The short yellow is still reported through last_len.
            state    <= S_FAULT;
            fault    <= 1'b1;
            code_q   <= FC_SHORT_Y;
            last_len <= cnt;
          end else begin
            state    <= next_state;
            phase_q  <= next_ph;
            last_len <= cnt;
            cnt      <= CNT_W'(1);
            if (state == S_RED) rotations <= rotations + 8'd1;
          end
        end
        default: ;  // S_FAULT holds everything until nrst or clr
      endcase
    end
  end

endmodule

// File: doc/stoplight_monitor.md
# stoplight_monitor

Checker for the lamp side of the stoplight controller. It samples the controller's `red`, `yellow` and `green` outputs every clock and tracks the phase sequence. It flags illegal lamp codes, out-of-order phases and yellow phases that are too short. It also reports the length of the last completed phase and counts full red→green rotations, so the lamp outputs can be checked on-chip or by the bench.

## Interface
Parameters:
- `CNT_W`, default 8: width of the phase-length counter and of `last_len`.
- `MIN_YELLOW`, default 4: minimum legal yellow duration in sampled cycles. Legal range is 1 ≤ MIN_YELLOW ≤ 2^CNT_W−1.

Ports:
- `clk`  in  1  — single clock. All sampling and state changes happen on its rising edge.
- `nrst`  in  1  — reset, asynchronous, active-low.
- `red`  in  1  — red lamp from the stoplight controller, synchronous to `clk`.
- `yellow`  in  1  — yellow lamp, synchronous to `clk`.
- `green`  in  1  — green lamp, synchronous to `clk`.
- `clr`  in  1  — synchronous clear. Same effect as reset, except `rotations` is preserved.
- `phase`  out  2  — tracked phase: 0 = IDLE, 1 = GREEN, 2 = YELLOW, 3 = RED. Holds the last phase while in FAULT.
- `fault`  out  1  — sticky fault flag.
- `fault_code`  out  2  — first fault seen: 0 = none, 1 = illegal lamp code, 2 = bad order, 3 = short yellow.
- `last_len`  out  CNT_W  — sampled-cycle length of the most recently completed phase.
- `rotations`  out  8  — count of RED→GREEN transitions, wrapping modulo 256.

## Operation
- Lamp code is `{red,yellow,green}`. Legal codes are one-hot: 001 = G, 010 = Y, 100 = R. 000 and any multi-hot code are illegal.
- State machine states: IDLE, GREEN, YELLOW, RED, FAULT.
- IDLE:
  - Illegal codes are ignored.
  - The first legal code moves to the matching state and loads cnt = 1.
  - No fault can be raised from IDLE.
- Tracking states (GREEN, YELLOW, RED):
  - Same code as the current state: cnt ← cnt+1, saturating at 2^CNT_W−1.
  - Legal next code (G→Y, Y→R, R→G):
    - `last_len` ← cnt;
    - cnt ← 1;
    - state advances;
    - on R→G, `rotations` ← `rotations`+1, wrapping 255→0.
  - Illegal lamp code: go to FAULT with code 1.
  - Legal but wrong next phase (G→R, Y→G, R→Y): go to FAULT with code 2.
  - Y→R with cnt < MIN_YELLOW: go to FAULT with code 3. `last_len` still loads cnt.
  - Fault priority, if more than one applies: 1 > 2 > 3. Y→G with a short yellow reports code 2.
- Entering FAULT:
  - `fault` ← 1.
  - `fault_code` latches the code and never changes while in FAULT.
  - `phase` keeps its pre-fault value.
  - cnt, `last_len` and `rotations` freeze.
- FAULT exits only through `nrst` low or `clr`.
- `clr` behaviour:
  - State goes to IDLE.
  - `fault` and `fault_code` clear.
  - cnt and `last_len` go to 0.
  - `rotations` is unchanged.
  - `clr` has priority over any lamp event sampled on the same edge; that lamp sample is discarded.

## Timing
- Reset values: `phase` = 0, `fault` = 0, `fault_code` = 0, `last_len` = 0, `rotations` = 0, cnt = 0, state IDLE. Reset takes effect immediately when `nrst` falls, independent of `clk`.
- `nrst` low mid-phase or mid-fault returns everything to reset values. The first legal code after release re-enters tracking.
- All outputs are registered with one-cycle latency. A new lamp code present before edge k is reflected in `phase`, `fault`, `last_len` and `rotations` immediately after edge k.
- Phase length counts edges at which the code was sampled. A lamp held for N edges gives `last_len` = N at the next transition.
- A saturated cnt compares as 2^CNT_W−1 in the short-yellow check.
- Single-cycle glitches are not filtered. A one-edge 000 or 011 during tracking is a code-1 fault.

## Test plan
- Legal sequence: reset, then R×5, G×6, Y×4, R×3.
  - `phase` reads 3, 1, 2, 3.
  - `last_len` reads 5, then 6, then 4.
  - `rotations` = 1; `fault` stays 0.
- Short yellow: with MIN_YELLOW = 4, drive G×3, Y×3, R.
  - `fault` = 1, `fault_code` = 3, `last_len` = 3.
  - Further legal codes change nothing.
- Order and glitch:
  - G then R gives code 2.
  - After `clr`, G×2 then 110 gives code 1.
  - Y(×2)→G with MIN_YELLOW = 4 gives code 2, not 3.
- Saturation and wrap:
  - With CNT_W = 4, hold G for 20 edges then Y: `last_len` = 15.
  - Run 256 full rotations: `rotations` wraps to 0.
- Clear and reset priority:
  - `clr` asserted on the same edge as a G→R order error: no fault, `phase` = 0, `rotations` preserved.
  - `nrst` pulsed low between edges while in FAULT: all outputs 0 immediately.
- IDLE tolerance: after reset drive 000, then 111, then G.
  - No fault; `phase` = 1 after the G edge.
